// File: rtl/cap_sense_scanner.sv
`default_nettype none
// ============================================================================
// Module      : cap_sense_scanner
// Description : Nine-channel RC capacitive touch scanner. One shared drive
//               line is discharged, then charged; the per-pin rise time
//               (in clock cycles) is latched, compared against THRESHOLD and
//               reported as a per-sensor touch state.
//               Optional: define CAP_SENSE_DEBOUNCE_EN to debounce 'touched'
//               over DEBOUNCE_SCANS consecutive agreeing scans.
// Revision    : 1.0 - initial release
// ============================================================================
module cap_sense_scanner #(
    parameter int DISCHARGE_CYCLES = 64,
    parameter int TIMEOUT_CYCLES   = 1023,
    parameter int THRESHOLD        = 200,
    parameter int DEBOUNCE_SCANS   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] capacitive_sensors_in,
    output logic       capacitive_sensors_out,
    output logic [8:0] touched,
    output logic       scan_done,
    input  logic [3:0] raw_count_sel,
    output logic [9:0] raw_count
);

    localparam int         c_NS        = 9;
    localparam int         c_DW        = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [9:0] c_TIMEOUT   = 10'(TIMEOUT_CYCLES);
    localparam logic [9:0] c_THRESHOLD = 10'(THRESHOLD);
    localparam logic [c_DW-1:0] c_DISC_LAST = c_DW'(DISCHARGE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISCHARGE = 2'd1,
        ST_CHARGE    = 2'd2,
        ST_EVALUATE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [8:0]      r_sync1;
    logic [8:0]      r_sync2;
    logic [c_DW-1:0] r_disc_cnt;
    logic [9:0]      r_charge_cnt;
    logic [8:0]      r_latched;
    logic [9:0]      r_work  [c_NS];
    logic [9:0]      r_count [c_NS];

    logic [8:0]      w_latched_next;
    logic            w_charge_done;
    logic            w_eval_strobe;
    logic [9:0]      w_final [c_NS];
    logic [8:0]      w_hit;

    // Two-flop synchronizer for the asynchronous sensor pins
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= capacitive_sensors_in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-sensor result of the current CHARGE cycle: first rise latches the
    // counter, earlier latches are kept, and anything still open at exit
    // is forced to the timeout value.
    always_comb begin
        w_latched_next = r_latched | r_sync2;
        w_charge_done  = (&w_latched_next) || (r_charge_cnt == c_TIMEOUT);
        w_eval_strobe  = (r_state == ST_CHARGE) && w_charge_done;
        for (int i = 0; i < c_NS; i++) begin
            if (r_latched[i]) begin
                w_final[i] = r_work[i];
            end else if (r_sync2[i]) begin
                w_final[i] = r_charge_cnt;
            end else begin
                w_final[i] = c_TIMEOUT;
            end
            w_hit[i] = (w_final[i] >= c_THRESHOLD);
        end
    end

    // Scan sequencer: IDLE -> DISCHARGE -> CHARGE -> EVALUATE
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state                <= ST_IDLE;
            capacitive_sensors_out <= 1'b0;
            scan_done              <= 1'b0;
            r_disc_cnt             <= '0;
            r_charge_cnt           <= '0;
            r_latched              <= '0;
            for (int i = 0; i < c_NS; i++) begin
                r_work[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            scan_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    capacitive_sensors_out <= 1'b0;
                    if (enable) begin
                        r_state    <= ST_DISCHARGE;
                        r_disc_cnt <= '0;
                    end
                end
                ST_DISCHARGE: begin
                    if (r_disc_cnt == c_DISC_LAST) begin
                        r_state                <= ST_CHARGE;
                        capacitive_sensors_out <= 1'b1;
                        r_charge_cnt           <= '0;
                        r_latched              <= '0;
                    end else begin
                        capacitive_sensors_out <= 1'b0;
                        r_disc_cnt             <= r_disc_cnt + 1'b1;
                    end
                end
                ST_CHARGE: begin
                    r_latched <= w_latched_next;
                    for (int i = 0; i < c_NS; i++) begin
                        r_work[i] <= w_final[i];
                    end
                    if (w_charge_done) begin
                        // Publish the finished scan; counts stay visible until the next one completes
                        r_state                <= ST_EVALUATE;
                        capacitive_sensors_out <= 1'b0;
                        scan_done              <= 1'b1;
                        for (int i = 0; i < c_NS; i++) begin
                            r_count[i] <= w_final[i];
                        end
                    end else if (r_charge_cnt < c_TIMEOUT) begin
                        r_charge_cnt <= r_charge_cnt + 1'b1;
                    end
                end
                ST_EVALUATE: begin
                    capacitive_sensors_out <= 1'b0;
                    r_disc_cnt             <= '0;
                    r_state                <= enable ? ST_DISCHARGE : ST_IDLE;
                end
                default: begin
                    r_state                <= ST_IDLE;
                    capacitive_sensors_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAP_SENSE_DEBOUNCE_EN
    localparam int             c_DBW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DEBOUNCE_SCANS - 1);

    logic [c_DBW-1:0] r_db_cnt [c_NS];

    // Touch state flips only after DEBOUNCE_SCANS consecutive scans disagree with it
    always_ff @(posedge clock) begin
        if (reset) begin
            touched <= '0;
            for (int i = 0; i < c_NS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else if (w_eval_strobe) begin
            for (int i = 0; i < c_NS; i++) begin
                if (w_hit[i] == touched[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] >= c_DB_LAST) begin
                    touched[i]  <= w_hit[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Touch state follows the most recent scan directly
    always_ff @(posedge clock) begin
        if (reset) begin
            touched <= '0;
        end else if (w_eval_strobe) begin
            touched <= w_hit;
        end
    end
`endif

    // Raw count readback; out-of-range selects read as zero
    always_comb begin
        raw_count = '0;
        for (int i = 0; i < c_NS; i++) begin
            if (raw_count_sel == 4'(i)) begin
                raw_count = r_count[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cap_sense_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cap_sense_scanner
// Description : Self-checking bench for cap_sense_scanner. Pin rise times are
//               scripted or random; expected counts, scan length, touch state
//               and readback come from a rise-time model of the sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cap_sense_scanner;

    localparam int NEVER = 5000;  // pin never rises during the scan
    localparam int PRE   = -1;    // pin already high before charge starts
    localparam int TMO   = 1023;
    localparam int THR   = 200;
    localparam int DB    = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [8:0] capacitive_sensors_in = '0;
    logic       capacitive_sensors_out;
    logic [8:0] touched;
    logic       scan_done;
    logic [3:0] raw_count_sel = '0;
    logic [9:0] raw_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0] m_touched = '0;
    int         m_prev [9];
    bit         m_prev_valid = 1'b0;
    bit         m_chain = 1'b0;
    logic [8:0] m_hit_log [64];
    int         m_nscans = 0;

    cap_sense_scanner dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .capacitive_sensors_in (capacitive_sensors_in),
        .capacitive_sensors_out(capacitive_sensors_out),
        .touched               (touched),
        .scan_done             (scan_done),
        .raw_count_sel         (raw_count_sel),
        .raw_count             (raw_count)
    );

    always #5 clock = ~clock;

    function automatic int exp_count(input int d);
        if (d < 0) return 0;
        if (d + 2 >= TMO) return TMO;
        return d + 2;
    endfunction

    function automatic void model_reset();
        m_touched    = '0;
        m_prev_valid = 1'b0;
        m_chain      = 1'b0;
        m_nscans     = 0;
    endfunction

    // Touch state: without debounce it is the latest hit vector; with
    // debounce a sensor flips once its last DB scans all voted against it.
    function automatic void model_update(input logic [8:0] hits);
`ifdef CAP_SENSE_DEBOUNCE_EN
        bit all_against;
        if (m_nscans < 64) begin
            m_hit_log[m_nscans] = hits;
            m_nscans++;
        end
        if (m_nscans >= DB) begin
            for (int i = 0; i < 9; i++) begin
                all_against = 1'b1;
                for (int j = 1; j <= DB; j++) begin
                    if (m_hit_log[m_nscans - j][i] == m_touched[i]) all_against = 1'b0;
                end
                if (all_against) m_touched[i] = ~m_touched[i];
            end
        end
`else
        m_touched = hits;
`endif
    endfunction

    // One full scan. drop_at: charge cycle at which enable falls (-1 none).
    // abort_at: charge cycle at which reset is asserted (-1 none).
    task automatic run_scan(input int d [9], input int drop_at, input int abort_at);
        int         exp [9];
        int         max_c;
        int         gap;
        int         exp_gap;
        int         k;
        int         done_k;
        int         sel;
        int         e;
        logic [8:0] hits;

        max_c = 0;
        for (int i = 0; i < 9; i++) begin
            exp[i] = exp_count(d[i]);
            if (exp[i] > max_c) max_c = exp[i];
            capacitive_sensors_in[i] = (d[i] < 0);
        end
        sel           = $urandom_range(0, 8);
        raw_count_sel = 4'(sel);
        exp_gap       = m_chain ? 64 : 65;
        enable        = 1'b1;

        gap = 0;
        while (!capacitive_sensors_out && gap < 200) begin
            @(posedge clock); #1;
            gap++;
        end
        checks++;
        if (gap !== exp_gap) begin
            errors++;
            $display("FAIL discharge_len: got %0d cycles expected %0d", gap, exp_gap);
        end

        k      = 0;
        done_k = -1;
        while (k < 1100) begin
            for (int i = 0; i < 9; i++) begin
                if (d[i] >= 0 && d[i] != NEVER && k >= d[i]) capacitive_sensors_in[i] = 1'b1;
            end
            if (k == drop_at) enable = 1'b0;
            if (k == 3) begin
                e = m_prev_valid ? m_prev[sel] : 0;
                checks++;
                if (raw_count !== 10'(e)) begin
                    errors++;
                    $display("FAIL hold_count sel=%0d: got %0d expected %0d", sel, raw_count, e);
                end
            end
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clock); #1;
                checks++;
                if (capacitive_sensors_out !== 1'b0 || touched !== 9'h0 || scan_done !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_outputs: got drive=%b touched=%h done=%b expected 0/000/0",
                             capacitive_sensors_out, touched, scan_done);
                end
                for (int s = 0; s < 16; s++) begin
                    raw_count_sel = 4'(s);
                    #0.3;
                    checks++;
                    if (raw_count !== 10'd0) begin
                        errors++;
                        $display("FAIL abort_raw sel=%0d: got %0d expected 0", s, raw_count);
                    end
                end
                reset                 = 1'b0;
                enable                = 1'b0;
                capacitive_sensors_in = '0;
                model_reset();
                return;
            end
            @(posedge clock); #1;
            k++;
            if (scan_done) begin
                done_k = k;
                break;
            end
        end

        checks++;
        if (done_k !== max_c + 1) begin
            errors++;
            $display("FAIL scan_len: got done at %0d expected %0d", done_k, max_c + 1);
        end
        checks++;
        if (capacitive_sensors_out !== 1'b0) begin
            errors++;
            $display("FAIL drive_eval: got %b expected 0", capacitive_sensors_out);
        end

        for (int i = 0; i < 9; i++) hits[i] = (exp[i] >= THR);
        model_update(hits);
        checks++;
        if (touched !== m_touched) begin
            errors++;
            $display("FAIL touched: got %h expected %h", touched, m_touched);
        end
        for (int s = 0; s < 16; s++) begin
            raw_count_sel = 4'(s);
            #0.3;
            e = (s < 9) ? exp[s] : 0;
            checks++;
            if (raw_count !== 10'(e)) begin
                errors++;
                $display("FAIL raw_count sel=%0d: got %0d expected %0d", s, raw_count, e);
            end
        end
        for (int i = 0; i < 9; i++) m_prev[i] = exp[i];
        m_prev_valid          = 1'b1;
        capacitive_sensors_in = '0;
        raw_count_sel         = 4'(sel);

        @(posedge clock); #1;
        checks++;
        if (scan_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got %b expected 0", scan_done);
        end
        m_chain = enable;
    endtask

    task automatic fill(output int d [9], input int v);
        for (int i = 0; i < 9; i++) d[i] = v;
    endtask

    task automatic test_reset();
        int bad;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (capacitive_sensors_out !== 1'b0 || touched !== 9'h0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got drive=%b touched=%h done=%b expected 0/000/0",
                     capacitive_sensors_out, touched, scan_done);
        end
        for (int s = 0; s < 16; s++) begin
            raw_count_sel = 4'(s);
            #0.3;
            checks++;
            if (raw_count !== 10'd0) begin
                errors++;
                $display("FAIL reset_raw sel=%0d: got %0d expected 0", s, raw_count);
            end
        end
        reset = 1'b0;
        model_reset();
        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (capacitive_sensors_out !== 1'b0 || scan_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_all_rise();
        int d [9];
        fill(d, 10);
        run_scan(d, -1, -1);
    endtask

    task automatic test_slow_pin4();
        int d [9];
        fill(d, 10);
        d[4] = 300;
        repeat (3) run_scan(d, -1, -1);
    endtask

    task automatic test_timeout_pin0();
        int d [9];
        fill(d, 10);
        d[0] = NEVER;
        repeat (3) run_scan(d, -1, -1);
    endtask

    task automatic test_debounce_release();
        int d [9];
        fill(d, 10);
        d[2] = 250;
        repeat (3) run_scan(d, -1, -1);
        fill(d, 10);
        repeat (3) run_scan(d, -1, -1);
    endtask

    task automatic test_random();
        int d [9];
        int r;
        repeat (5) begin
            for (int i = 0; i < 9; i++) begin
                r = $urandom_range(0, 19);
                if (r == 0)      d[i] = NEVER;
                else if (r == 1) d[i] = PRE;
                else if (r == 2) d[i] = $urandom_range(195, 200);
                else             d[i] = $urandom_range(0, 400);
            end
            run_scan(d, -1, -1);
        end
    endtask

    task automatic test_back_to_back();
        int d [9];
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 9; i++) d[i] = (n == 1) ? PRE : $urandom_range(0, 30);
            run_scan(d, -1, -1);
        end
    endtask

    task automatic test_enable_drop();
        int d [9];
        int bad;
        fill(d, 10);
        d[6] = 50;
        run_scan(d, 20, -1);
        bad = 0;
        repeat (200) begin
            @(posedge clock); #1;
            if (capacitive_sensors_out !== 1'b0 || scan_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_drop_idle: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_charge();
        int d [9];
        fill(d, 250);
        repeat (3) run_scan(d, -1, -1);
        run_scan(d, -1, 30);
        fill(d, 10);
        d[8] = 220;
        run_scan(d, -1, -1);
    endtask

    initial begin
        test_reset();
        test_all_rise();
        test_slow_pin4();
        test_timeout_pin0();
        test_debounce_release();
        test_random();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_charge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cap_sense_scanner.md
CAP_SENSE_SCANNER -- requirements
Module: cap_sense_scanner

Interface
REQ-001 SHALL have parameter DISCHARGE_CYCLES, default 64, number of cycles the drive line is held low before each charge phase.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023, maximum charge-phase count; it is also the saturation value of every count (10-bit).
REQ-003 SHALL have parameter THRESHOLD, default 200, count at or above which a sensor is hit.
REQ-004 SHALL have parameter DEBOUNCE_SCANS, default 3, consecutive agreeing scans required to change touched (used only with debounce compiled in).
REQ-005 SHALL have port clock, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, scanning permitted while high.
REQ-008 SHALL have port capacitive_sensors_in, input, 9, asynchronous sensor pin levels.
REQ-009 SHALL have port capacitive_sensors_out, output, 1, shared charge drive line for all nine sensors.
REQ-010 SHALL have port touched, output, 9, registered per-sensor touch state.
REQ-011 SHALL have port scan_done, output, 1, one-cycle pulse per completed scan.
REQ-012 SHALL have port raw_count_sel, input, 4, sensor index for raw_count.
REQ-013 SHALL have port raw_count, output, 10, latched count of the selected sensor; 0 when raw_count_sel > 8.

Function
REQ-014 SHALL pass capacitive_sensors_in through a two-flop synchronizer; measurement uses only synchronized bits.
REQ-015 SHALL implement FSM states IDLE, DISCHARGE, CHARGE, EVALUATE.
REQ-016 IDLE: drive line 0; transitions to DISCHARGE on the cycle after enable is sampled high.
REQ-017 DISCHARGE: drive line 0 for exactly DISCHARGE_CYCLES cycles, then CHARGE.
REQ-018 CHARGE: drive line 1; cycle counter starts at 0 on the first CHARGE cycle and increments by 1 per cycle.
REQ-019 In CHARGE, for each sensor i, on the first cycle its synchronized bit is 1, count[i] SHALL latch the counter value; later edges of that sensor SHALL be ignored in the same scan.
REQ-020 CHARGE SHALL exit to EVALUATE when all nine counts are latched or the counter equals TIMEOUT_CYCLES; unlatched sensors then get count = TIMEOUT_CYCLES.
REQ-021 Counter and counts SHALL saturate at TIMEOUT_CYCLES and never wrap.
REQ-022 A sensor already high on the first CHARGE cycle SHALL latch count 0 (not hit).
REQ-023 EVALUATE lasts one cycle: hit[i] = (count[i] >= THRESHOLD); touched updated per REQ-028/029; scan_done = 1 for that cycle only.
REQ-024 From EVALUATE: DISCHARGE if enable = 1, else IDLE.
REQ-025 Deassertion of enable mid-scan SHALL NOT abort the scan; the scan completes with one scan_done, then IDLE.
REQ-026 raw_count SHALL be combinational from latched counts and raw_count_sel; counts hold until overwritten by the next EVALUATE-bound scan.

Reset
REQ-027 On reset sampled high: state IDLE; capacitive_sensors_out, touched, scan_done, all counts, counters, synchronizer flops and debounce counters = 0 at that edge, including when asserted mid-CHARGE.

Configuration
REQ-028 With CAP_SENSE_DEBOUNCE_EN defined: per-sensor saturating agreement counter; touched[i] sets after DEBOUNCE_SCANS consecutive hit scans and clears after DEBOUNCE_SCANS consecutive non-hit scans; any disagreeing scan resets that counter to 0.
REQ-029 Without CAP_SENSE_DEBOUNCE_EN: touched = hit from the most recent EVALUATE; no debounce registers present.

Verification
REQ-030 Reset, enable=1, all pins rise N=10 cycles after capacitive_sensors_out rises -> scan_done pulses, every raw_count = 12 (synchronizer +2), touched = 0.
REQ-031 Pin 4 rises after 300 cycles, others after 10 -> no debounce: touched = 9'h010 after scan 1; debounce: touched = 9'h010 only after scan 3.
REQ-032 Pin 0 never rises, others after 10 -> CHARGE exits at count 1023, raw_count (sel 0) = 1023, touched[0] = 1 (after 3 scans with debounce).
REQ-033 enable dropped mid-CHARGE -> exactly one further scan_done, then IDLE with capacitive_sensors_out = 0 and no further DISCHARGE.
REQ-034 reset asserted mid-CHARGE -> next edge: capacitive_sensors_out = 0, touched = 0, scan_done = 0, raw_count = 0 for all sel.
REQ-035 Debounce build, touched[2] = 1, then two non-hit scans -> stays 1; third consecutive non-hit -> clears; raw_count_sel = 9 -> raw_count = 0.
